// File: rtl/div_mant_approx_seq_if.sv
// Request/result bundle for the truncated-significand mantissa divider.
interface div_mant_approx_seq_if;
    logic        start;
    logic [30:0] a_operand;
    logic [30:0] b_operand;
    logic        busy;
    logic        done;
    logic        normalised;
    logic [22:0] quotient_mantissa;
    logic        div_by_zero;

    modport master (
        output start, a_operand, b_operand,
        input  busy, done, normalised, quotient_mantissa, div_by_zero
    );
    modport slave (
        input  start, a_operand, b_operand,
        output busy, done, normalised, quotient_mantissa, div_by_zero
    );
endinterface

// File: rtl/div_mant_approx_seq.sv
// Approximate mantissa divider: keeps the top R bits of each hidden significand
// and runs a 25-step restoring division, one quotient bit per cycle.
module div_mant_approx_seq #(
    parameter int R = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    div_mant_approx_seq_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam logic [23:0] MASK = ~((24'd1 << (24 - R)) - 24'd1);

    state_t      r_state, w_next;
    logic [24:0] r_rem;
    logic [24:0] r_q;
    logic [23:0] r_b;
    logic [4:0]  r_cnt;
    logic        r_norm;
    logic [22:0] r_mant;
    logic        r_dbz;

    logic [23:0] w_a, w_b;
    logic        w_accept, w_bzero, w_ge;
    logic [24:0] w_sub, w_q;

    assign w_a      = {|bus.a_operand[30:23], bus.a_operand[22:0]} & MASK;
    assign w_b      = {|bus.b_operand[30:23], bus.b_operand[22:0]} & MASK;
    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_bzero  = (w_b == 24'd0);

    // Remainder starts as A; each step compares against B then shifts left,
    // so bit 24 of Q is produced first.
    assign w_ge  = (r_rem >= {1'b0, r_b});
    assign w_sub = w_ge ? (r_rem - {1'b0, r_b}) : r_rem;
    assign w_q   = (r_q << 1) | {24'd0, w_ge};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = w_bzero ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == 5'd0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_q    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_norm <= 1'b0;
            r_mant <= '0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rem <= {1'b0, w_a};
                        r_b   <= w_b;
                        r_q   <= '0;
                        r_cnt <= 5'd24;
                        if (w_bzero) begin
                            r_dbz  <= 1'b1;
                            r_norm <= 1'b1;
                            r_mant <= 23'h7FFFFF;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_sub << 1;
                    r_q   <= w_q;
                    if (r_cnt != 5'd0) begin
                        r_cnt <= r_cnt - 5'd1;
                    end else begin
                        // Last bit lands this edge, so results come from w_q.
                        r_norm <= w_q[24];
                        r_mant <= w_q[24] ? w_q[23:1] : w_q[22:0];
                        r_dbz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy              = (r_state == S_CALC);
    assign bus.done              = (r_state == S_DONE);
    assign bus.normalised        = r_norm;
    assign bus.quotient_mantissa = r_mant;
    assign bus.div_by_zero       = r_dbz;
endmodule
